// File: rtl/cacheline_adaptor.sv
// Bridges a full-line cache request to a 4-beat burst on the main-memory bus.
// Reads assemble beats into a line; writes stream a latched line out beat by beat.
module cacheline_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64,
    localparam int BEATS      = LINE_WIDTH / BURST_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            address_i,
    input  logic                   read_i,
    input  logic                   write_i,
    input  logic [LINE_WIDTH-1:0]  line_i,
    output logic [LINE_WIDTH-1:0]  line_o,
    output logic                   resp_o,
    output logic [31:0]            address_o,
    output logic                   read_o,
    output logic                   write_o,
    input  logic [BURST_WIDTH-1:0] burst_i,
    output logic [BURST_WIDTH-1:0] burst_o,
    input  logic                   resp_i
);

    localparam int               CNT_W      = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
    localparam logic [31:0]      ALIGN_MASK = ~(32'(LINE_WIDTH / 8) - 32'd1);

    typedef enum logic [2:0] {
        IDLE,
        RD_BURST,
        RD_DONE,
        WR_BURST,
        WR_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q;
    logic [31:0]             addr_q;
    logic [LINE_WIDTH-1:0]   buf_q;
    logic [LINE_WIDTH-1:0]   line_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (read_i)       state_d = RD_BURST;
                else if (write_i) state_d = WR_BURST;
            end
            RD_BURST: if (resp_i && cnt_q == LAST_BEAT) state_d = RD_DONE;
            WR_BURST: if (resp_i && cnt_q == LAST_BEAT) state_d = WR_DONE;
            RD_DONE:  state_d = IDLE;
            WR_DONE:  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // buf_q doubles as the read assembly buffer and the latched write line;
    // line_q only updates on the final read beat so line_o never shows a partial line.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            addr_q <= '0;
            buf_q  <= '0;
            line_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (read_i || write_i) begin
                        addr_q <= address_i & ALIGN_MASK;
                        cnt_q  <= '0;
                        if (!read_i) buf_q <= line_i;
                    end
                end
                RD_BURST: begin
                    if (resp_i) begin
                        buf_q[BURST_WIDTH*cnt_q +: BURST_WIDTH] <= burst_i;
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_BEAT)
                            line_q <= {burst_i, buf_q[LINE_WIDTH-BURST_WIDTH-1:0]};
                    end
                end
                WR_BURST: if (resp_i) cnt_q <= cnt_q + CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign read_o    = (state_q == RD_BURST);
    assign write_o   = (state_q == WR_BURST);
    assign resp_o    = (state_q == RD_DONE) || (state_q == WR_DONE);
    assign address_o = addr_q;
    assign line_o    = line_q;
    assign burst_o   = write_o ? buf_q[BURST_WIDTH*cnt_q +: BURST_WIDTH] : '0;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Table-driven bench for cacheline_adaptor with a memory model and a response scoreboard.
module tb_cacheline_adaptor;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  address_i, address_o;
    logic         read_i, write_i, read_o, write_o, resp_o, resp_i;
    logic [255:0] line_i, line_o;
    logic [63:0]  burst_i, burst_o;

    always #5 clk = ~clk;

    cacheline_adaptor dut (
        .clk(clk), .rst(rst),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .line_i(line_i),
        .line_o(line_o), .resp_o(resp_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o),
        .burst_i(burst_i), .burst_o(burst_o), .resp_i(resp_i)
    );

    typedef struct {
        bit           rd;
        bit           wr;
        logic [31:0]  addr;
        logic [255:0] wline;
        logic [255:0] mem;
        logic [15:0]  ack;       // per burst cycle, LSB first: 1 = memory acks
        bit           tgl;       // toggle line_i/address_i during the burst
        bit           exp_rd;
        logic [31:0]  exp_addr;
        logic [255:0] exp_line;
    } vec_t;

    typedef struct {
        bit           rd;
        logic [255:0] line;
        int           cyc;
    } sb_t;

    sb_t  sbq[$];
    vec_t vt[6];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    // Starts at a negedge in IDLE; returns at the negedge of the IDLE cycle after resp_o.
    task automatic run_txn(input vec_t v);
        sb_t e, r;
        int  nack, beats, k;
        bit  done, ack_now;
        nack = 0; e.cyc = 0;
        for (int i = 0; i < 16; i++)
            if (v.ack[i]) begin
                nack++;
                if (nack == 4 && e.cyc == 0) e.cyc = i + 2;
            end
        e.rd = v.exp_rd; e.line = v.exp_line;
        sbq.push_back(e);
        read_i = v.rd; write_i = v.wr; address_i = v.addr; line_i = v.wline;
        beats = 0; k = 0; done = 0;
        for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
            @(negedge clk);
            resp_i  = 1'b0;
            burst_i = {$urandom, $urandom};
            if (resp_o) begin
                r = sbq.pop_front();
                chk("resp_cycle", cyc, r.cyc);
                chk("line_o", line_o, r.line);
                chk("beats_acked", beats, 4);
                read_i = 1'b0; write_i = 1'b0;
                done = 1;
            end else if (read_o || write_o) begin
                chk("read_o", read_o, sbq[0].rd);
                chk("write_o", write_o, !sbq[0].rd);
                chk("address_o", address_o, v.exp_addr);
                if (write_o && beats < 4) chk("burst_o", burst_o, v.wline[64*beats +: 64]);
                if (v.tgl) begin line_i = ~line_i; address_i = ~address_i; end
                ack_now = (k < 16) ? v.ack[k] : 1'b1;
                if (ack_now) begin
                    resp_i = 1'b1;
                    if (read_o && beats < 4) burst_i = v.mem[64*beats +: 64];
                    beats++;
                end
                k++;
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL txn_timeout act=no_resp exp=resp_o");
            if (sbq.size() > 0) void'(sbq.pop_front());
            read_i = 1'b0; write_i = 1'b0;
        end
        @(negedge clk);
        resp_i = 1'b0;
        chk("idle_after_resp", {resp_o, read_o, write_o}, 3'b000);
    endtask

    localparam logic [255:0] M1 = {{4{16'h4444}}, {4{16'h3333}}, {4{16'h2222}}, {4{16'h1111}}};
    localparam logic [255:0] W1 = {{4{16'hDDDD}}, {4{16'hCCCC}}, {4{16'hBBBB}}, {4{16'hAAAA}}};
    localparam logic [255:0] M2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                   64'hDEAD_BEEF_CAFE_F00D, 64'h0F0F_F0F0_5A5A_A5A5};
    localparam logic [255:0] M3 = {64'h3333_0000_0000_0004, 64'h3333_0000_0000_0003,
                                   64'h3333_0000_0000_0002, 64'h3333_0000_0000_0001};
    localparam logic [255:0] W2 = {64'h7777_0000_0000_000D, 64'h7777_0000_0000_000C,
                                   64'h7777_0000_0000_000B, 64'h7777_0000_0000_000A};
    localparam logic [255:0] M4 = {64'h8000_0000_0000_0001, 64'h0000_0000_0000_0080,
                                   64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000};

    initial begin
        //          rd wr addr           wline mem   ack       tgl exp_rd exp_addr       exp_line
        vt[0] = '{1, 0, 32'h0000_1234, '0,   M1,   16'h000F, 0,  1,     32'h0000_1220, M1};
        vt[1] = '{0, 1, 32'hABCD_EF77, W1,   '0,   16'h0059, 1,  0,     32'hABCD_EF60, M1};
        vt[2] = '{1, 1, 32'h8000_001F, W1,   M2,   16'h0155, 0,  1,     32'h8000_0000, M2};
        vt[3] = '{1, 0, 32'h0000_0FE0, '0,   M3,   16'h000F, 0,  1,     32'h0000_0FE0, M3};
        vt[4] = '{0, 1, 32'h1234_5678, W2,   '0,   16'h000F, 0,  0,     32'h1234_5660, M3};
        vt[5] = '{1, 0, 32'hFFFF_FFFF, '0,   M4,   16'h003B, 0,  1,     32'hFFFF_FFE0, M4};

        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        address_i = '0; line_i = '0; burst_i = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_read_o", read_o, 1'b0);
        chk("rst_write_o", write_o, 1'b0);
        chk("rst_resp_o", resp_o, 1'b0);
        chk("rst_address_o", address_o, 32'h0);
        chk("rst_burst_o", burst_o, 64'h0);
        chk("rst_line_o", line_o, 256'h0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_txn(vt[i]);

        // memory acks while idle must be ignored
        for (int i = 0; i < 3; i++) begin
            resp_i = 1'b1; burst_i = {$urandom, $urandom};
            @(negedge clk);
            chk("spurious_outs", {resp_o, read_o, write_o}, 3'b000);
            chk("spurious_line_o", line_o, M3);
        end
        resp_i = 1'b0;

        // abort a read after two beats
        read_i = 1'b1; address_i = 32'h0000_0040;
        @(negedge clk);
        chk("abort_read_o_pre", read_o, 1'b1);
        resp_i = 1'b1; burst_i = 64'hAAAA_0000_0000_0001;
        @(negedge clk);
        resp_i = 1'b1; burst_i = 64'hAAAA_0000_0000_0002;
        @(negedge clk);
        resp_i = 1'b0; rst = 1'b1; read_i = 1'b0;
        @(negedge clk);
        chk("abort_read_o", read_o, 1'b0);
        chk("abort_resp_o", resp_o, 1'b0);
        chk("abort_line_o", line_o, 256'h0);
        chk("abort_address_o", address_o, 32'h0);
        rst = 1'b0;
        run_txn(vt[5]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
